idli_sqi_ctrl_m: RTL and testbench
==================================

// Module: idli_sqi_ctrl_m
//
// PURPOSE
//  SQI memory initiator. It turns a read/write request into an SQI transaction:
//  chip select, command nibbles, address nibbles, dummy turnaround, then the
//  data phase. It drives the 4b SIO bus toward the external memory.
//  Read nibbles returned by the memory go to the read-side reorder buffer, with
//  a write enable issued one cycle ahead of the data. Write nibbles are pulled
//  from the requester MSB-first.
//
// PARAMETERS
//  ADDR_NIBBLES  4  address length in nibbles; address width = 4*ADDR_NIBBLES
//  DUMMY_CYCLES  2  read turnaround cycles between address and data; >=1
//  LEN_W         8  width of the request length field
//
// PORTS
//  i_sqi_gck     in   1               clock
//  i_sqi_rst_n   in   1               reset, asynchronous, active-low
//  i_req_vld     in   1               request valid
//  o_req_rdy     out  1               request ready; accept = vld & rdy
//  i_req_wr      in   1               1 = write, 0 = read
//  i_req_addr    in   4*ADDR_NIBBLES  start address
//  i_req_len     in   LEN_W           words - 1 (16b words)
//  i_wr_data     in   sqi_data_t      write nibble, valid in cycles where o_wr_ack=1
//  o_wr_ack      out  1               write nibble consumed this cycle
//  o_sqi_cs_n    out  1               memory chip select, active-low
//  o_sqi_oe      out  1               SIO output enable
//  o_sqi_sio     out  sqi_data_t      SIO data out
//  i_sqi_sio     in   sqi_data_t      SIO data in
//  o_buf_wr_en   out  1               read-buffer write enable, one cycle ahead of o_rd_data
//  o_rd_data     out  sqi_data_t      read nibble (registered)
//  o_rd_vld      out  1               o_rd_data valid
//
// BEHAVIOUR
//  - FSM states: IDLE -> CMD(2) -> ADDR(ADDR_NIBBLES) -> [DUMMY(DUMMY_CYCLES), read only] -> DATA(4*(len+1)) -> DONE(1) -> IDLE.
//  - Reset (async, any state): state=IDLE and counters=0.
//    - Output reset values: cs_n=1, oe=0, sio=0, rd_vld=0, rd_data=0, buf_wr_en=0, wr_ack=0, req_rdy=1.
//  - o_req_rdy = (state==IDLE). On accept, wr/addr/len are latched.
//    - Request inputs are ignored outside IDLE.
//  - cs_n is low exactly in CMD, ADDR, DUMMY and DATA. It goes low the cycle after accept.
//    - It is high in DONE, so cs_n is high for >=2 cycles between transactions.
//  - CMD drives the command byte MSB nibble first: read 0x03 -> 0,3; write 0x02 -> 0,2.
//  - ADDR drives the address MSB nibble first.
//  - oe=1 in CMD, ADDR and write DATA; oe=0 in DUMMY and read DATA.
//    - oe is never high in the cycle after a read DATA cycle.
//  - Write DATA:
//    - o_sqi_sio = i_wr_data combinationally and o_wr_ack=1 every cycle.
//    - Exactly 4*(len+1) acks per transaction.
//  - Read DATA: i_sqi_sio is sampled every cycle.
//    - o_rd_data/o_rd_vld present the sampled nibble the following cycle.
//    - o_buf_wr_en=1 in every read DATA cycle, one cycle ahead of o_rd_vld.
//  - Counters: 2b nibble counter, LEN_W word counter counting down from len.
//    - DATA ends when nibble=3 and word=0. len=all-ones gives 2^LEN_W words with no wrap or early exit.
//  - Latency from accept at cycle T:
//    - First data cycle (read) is T+1+2+ADDR_NIBBLES+DUMMY_CYCLES.
//    - First data cycle (write) is T+1+2+ADDR_NIBBLES.
//  - Reset mid-transaction aborts immediately: cs_n=1 and oe=0 asynchronously.
//    - No further acks or rd_vld are produced.
//  - o_sqi_sio=0 whenever oe=0.
//
// STRUCTURE
//  - In idli_pkg:
//    - sqi_state_t enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE).
//    - sqi_cmd_t constants SQI_CMD_READ=8'h03, SQI_CMD_WRITE=8'h02.
//    - sqi_data_t stays in idli_pkg.
//  - No sub-module; the read-nibble reorder is done by the existing SQI buffer outside this block.
//  - Single FSM plus counters, with a registered read path.
//
// TESTING
//  - Read, addr 0x1234, len 0:
//    - SIO = 0,3,1,2,3,4 with oe=1 (6 cycles), then oe=0 for 2 dummy + 4 data cycles.
//    - Memory drives A,B,C,D -> rd_data A,B,C,D each one cycle later; buf_wr_en leads rd_vld by 1; cs_n low 12 cycles.
//  - Write, addr 0xFFFF, len 1, data 0xBEEF,0x1234:
//    - SIO = 0,2,F,F,F,F,B,E,E,F,1,2,3,4 with oe=1 throughout.
//    - 8 wr_ack pulses; no dummy cycles.
//  - Back-to-back, req_vld held high:
//    - Second request accepted in the first IDLE after DONE.
//    - cs_n high exactly 2 cycles between transactions.
//  - Read, len 255: exactly 1024 read DATA cycles and 1024 rd_vld pulses, then DONE.
//  - Request inputs changed while busy (vld=1, new addr/wr): no effect on the in-flight transaction; rdy stays 0.
//  - i_sqi_rst_n=0 in the 3rd write DATA cycle: cs_n=1 and oe=0 before the next edge; rdy=1.
//    - After release, a new read runs cleanly.

Source files
------------

// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared SQI types and command constants
package idli_pkg;

    typedef logic [3:0] sqi_data_t;
    typedef logic [7:0] sqi_cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5
    } sqi_state_t;

    localparam sqi_cmd_t SQI_CMD_READ  = 8'h03;
    localparam sqi_cmd_t SQI_CMD_WRITE = 8'h02;

endpackage

// File: rtl/idli_sqi_ctrl_m_if.sv
// rtl/idli_sqi_ctrl_m_if.sv - request, write-data, SIO and read-buffer signals of the SQI initiator
interface idli_sqi_ctrl_m_if #(
    parameter int ADDR_NIBBLES = 4,
    parameter int LEN_W        = 8
);
    import idli_pkg::*;

    logic                      i_req_vld;
    logic                      o_req_rdy;
    logic                      i_req_wr;
    logic [4*ADDR_NIBBLES-1:0] i_req_addr;
    logic [LEN_W-1:0]          i_req_len;
    sqi_data_t                 i_wr_data;
    logic                      o_wr_ack;
    logic                      o_sqi_cs_n;
    logic                      o_sqi_oe;
    sqi_data_t                 o_sqi_sio;
    sqi_data_t                 i_sqi_sio;
    logic                      o_buf_wr_en;
    sqi_data_t                 o_rd_data;
    logic                      o_rd_vld;

    // master: requester plus memory side; slave: the initiator itself
    modport master (
        output i_req_vld, i_req_wr, i_req_addr, i_req_len, i_wr_data, i_sqi_sio,
        input  o_req_rdy, o_wr_ack, o_sqi_cs_n, o_sqi_oe, o_sqi_sio,
               o_buf_wr_en, o_rd_data, o_rd_vld
    );

    modport slave (
        input  i_req_vld, i_req_wr, i_req_addr, i_req_len, i_wr_data, i_sqi_sio,
        output o_req_rdy, o_wr_ack, o_sqi_cs_n, o_sqi_oe, o_sqi_sio,
               o_buf_wr_en, o_rd_data, o_rd_vld
    );

endinterface

// File: rtl/idli_sqi_ctrl_m.sv
// rtl/idli_sqi_ctrl_m.sv - SQI memory initiator: command, address, dummy and data phases
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int ADDR_NIBBLES = 4,
    parameter int DUMMY_CYCLES = 2,
    parameter int LEN_W        = 8
) (
    input  logic               i_sqi_gck,
    input  logic               i_sqi_rst_n,
    idli_sqi_ctrl_m_if.slave   bus
);

    localparam int                ADDR_W     = 4 * ADDR_NIBBLES;
    localparam int                STEP_W     = 8;
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
    localparam logic [STEP_W-1:0] ADDR_LAST  = STEP_W'(ADDR_NIBBLES - 1);
    localparam logic [STEP_W-1:0] DUMMY_LAST = STEP_W'(DUMMY_CYCLES - 1);

    sqi_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        nib_q, nib_d;
    logic [LEN_W-1:0]  word_q, word_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    sqi_cmd_t          cmd;

    logic              cs_n, oe, wr_ack, buf_wr_en;
    sqi_data_t         sio;
    logic              rd_vld_q;
    sqi_data_t         rd_data_q;

    assign cmd = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            nib_q   <= '0;
            word_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            nib_q   <= nib_d;
            word_q  <= word_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        nib_d     = nib_q;
        word_d    = word_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        cs_n      = 1'b1;
        oe        = 1'b0;
        sio       = '0;
        wr_ack    = 1'b0;
        buf_wr_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req_vld) begin
                    state_d = CMD;
                    step_d  = '0;
                    nib_d   = '0;
                    wr_d    = bus.i_req_wr;
                    addr_d  = bus.i_req_addr;
                    word_d  = bus.i_req_len;
                end
            end
            CMD: begin
                cs_n = 1'b0;
                oe   = 1'b1;
                sio  = step_q[0] ? cmd[3:0] : cmd[7:4];
                if (step_q == STEP_ONE) begin
                    state_d = ADDR;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            ADDR: begin
                // address is shifted out of the top nibble, MSB first
                cs_n   = 1'b0;
                oe     = 1'b1;
                sio    = addr_q[ADDR_W-1 -: 4];
                addr_d = addr_q << 4;
                if (step_q == ADDR_LAST) begin
                    state_d = wr_q ? DATA : DUMMY;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            DUMMY: begin
                cs_n = 1'b0;
                if (step_q == DUMMY_LAST) begin
                    state_d = DATA;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            DATA: begin
                cs_n = 1'b0;
                if (wr_q) begin
                    oe     = 1'b1;
                    sio    = bus.i_wr_data;
                    wr_ack = 1'b1;
                end else begin
                    buf_wr_en = 1'b1;
                end
                nib_d = nib_q + 2'd1;
                // word counter only steps on the last nibble, so len=all-ones runs the full range
                if (nib_q == 2'd3) begin
                    if (word_q == '0) begin
                        state_d = DONE;
                    end else begin
                        word_d = word_q - LEN_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= buf_wr_en;
            if (buf_wr_en) begin
                rd_data_q <= bus.i_sqi_sio;
            end
        end
    end

    assign bus.o_req_rdy   = (state_q == IDLE);
    assign bus.o_wr_ack    = wr_ack;
    assign bus.o_sqi_cs_n  = cs_n;
    assign bus.o_sqi_oe    = oe;
    assign bus.o_sqi_sio   = sio;
    assign bus.o_buf_wr_en = buf_wr_en;
    assign bus.o_rd_data   = rd_data_q;
    assign bus.o_rd_vld    = rd_vld_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb/tb_idli_sqi_ctrl_m.sv - scoreboard bench for the SQI initiator with a decoding memory model
module tb_idli_sqi_ctrl_m;
    import idli_pkg::*;

    localparam int AN = 4;
    localparam int DC = 2;
    localparam int LW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    idli_sqi_ctrl_m_if #(.ADDR_NIBBLES(AN), .LEN_W(LW)) bus();

    idli_sqi_ctrl_m #(.ADDR_NIBBLES(AN), .DUMMY_CYCLES(DC), .LEN_W(LW)) dut (
        .i_sqi_gck  (clk),
        .i_sqi_rst_n(rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(bit ok, string name, longint act, longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // memory contents as a plain function of the word address
    function automatic logic [15:0] mem_word(logic [15:0] a);
        if (a == 16'h1234) return 16'hABCD;
        return 16'((32'(a) * 32'd40503) ^ 32'h0000A5C3);
    endfunction

    logic [3:0]  sio_exp[$];
    logic [3:0]  rd_exp[$];
    logic [3:0]  wr_src[$];
    logic [15:0] wr_fixed[$];
    int          cs_len_exp[$];

    // ---------------- monitor ----------------
    int         cs_cnt = 0;
    int         gap_cnt = 100;
    bit         gap_armed = 0;
    bit         prev_bwe = 0;
    int         rdv_total = 0;
    logic [3:0] mon_e;
    int         mon_len;

    always @(negedge clk) begin
        if (rst_n) begin
            chk(bus.o_rd_vld == prev_bwe, "rd_vld_lags_buf_wr_en", bus.o_rd_vld, prev_bwe);
            prev_bwe = bus.o_buf_wr_en;
            if (bus.o_sqi_oe) begin
                chk(!bus.o_sqi_cs_n, "cs_low_with_oe", bus.o_sqi_cs_n, 0);
                if (sio_exp.size() == 0) begin
                    chk(0, "unexpected_oe", bus.o_sqi_sio, 0);
                end else begin
                    mon_e = sio_exp.pop_front();
                    chk(bus.o_sqi_sio == mon_e, "sio", bus.o_sqi_sio, mon_e);
                end
            end else begin
                chk(bus.o_sqi_sio == 4'h0, "sio_zero_when_oe_low", bus.o_sqi_sio, 0);
            end
            if (bus.o_buf_wr_en) begin
                chk(!bus.o_sqi_cs_n && !bus.o_sqi_oe, "buf_wr_en_phase", {bus.o_sqi_cs_n, bus.o_sqi_oe}, 0);
            end
            if (bus.o_rd_vld) begin
                rdv_total++;
                if (rd_exp.size() == 0) begin
                    chk(0, "unexpected_rd_vld", bus.o_rd_data, 0);
                end else begin
                    mon_e = rd_exp.pop_front();
                    chk(bus.o_rd_data == mon_e, "rd_data", bus.o_rd_data, mon_e);
                end
            end
            if (!bus.o_sqi_cs_n) begin
                if (cs_cnt == 0) begin
                    chk(gap_cnt >= 2, "cs_high_gap_min", gap_cnt, 2);
                    if (gap_armed) begin
                        chk(gap_cnt == 2, "b2b_cs_gap", gap_cnt, 2);
                        gap_armed = 0;
                    end
                end
                cs_cnt++;
            end else begin
                if (cs_cnt > 0) begin
                    if (cs_len_exp.size() == 0) begin
                        chk(0, "unexpected_cs_window", cs_cnt, 0);
                    end else begin
                        mon_len = cs_len_exp.pop_front();
                        chk(cs_cnt == mon_len, "cs_low_cycles", cs_cnt, mon_len);
                    end
                    cs_cnt  = 0;
                    gap_cnt = 0;
                end
                gap_cnt++;
            end
        end else begin
            chk(!bus.o_wr_ack && !bus.o_rd_vld && bus.o_sqi_cs_n && !bus.o_sqi_oe, "quiet_in_reset",
                {bus.o_wr_ack, bus.o_rd_vld, bus.o_sqi_cs_n, bus.o_sqi_oe}, 4'b0010);
            prev_bwe = 0;
        end
    end

    // ---------------- write-data source ----------------
    bit ack_seen = 0;
    always @(negedge clk) ack_seen = bus.o_wr_ack;

    always @(posedge clk) begin
        #1;
        if (ack_seen && rst_n) begin
            if (wr_src.size() == 0) chk(0, "extra_wr_ack", 1, 0);
            else void'(wr_src.pop_front());
        end
        ack_seen = 0;
        bus.i_wr_data = (wr_src.size() != 0) ? wr_src[0] : 4'h0;
    end

    // ---------------- memory model: decodes the bus like the real part ----------------
    int          mem_idx = 0;
    bit          mem_prev_low = 0;
    logic [7:0]  mem_cmd = 8'h00;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] mem_w;
    int          mem_k;

    always @(posedge clk) begin
        #1;
        if (!bus.o_sqi_cs_n) begin
            mem_idx      = mem_prev_low ? mem_idx + 1 : 0;
            mem_prev_low = 1;
        end else begin
            mem_prev_low = 0;
        end
        if (!bus.o_sqi_cs_n && mem_cmd == 8'h03 && mem_idx >= 2 + AN + DC) begin
            mem_k = mem_idx - (2 + AN + DC);
            mem_w = mem_word(mem_addr + 16'(mem_k / 4));
            bus.i_sqi_sio = 4'(mem_w >> (4 * (3 - (mem_k % 4))));
        end else begin
            bus.i_sqi_sio = 4'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!bus.o_sqi_cs_n && bus.o_sqi_oe) begin
            if (mem_idx < 2) mem_cmd = {mem_cmd[3:0], bus.o_sqi_sio};
            else if (mem_idx < 2 + AN) mem_addr = {mem_addr[11:0], bus.o_sqi_sio};
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(bit wr, logic [15:0] addr, logic [7:0] len, bit keep_vld);
        logic [15:0] w;
        int n;
        cs_len_exp.push_back(2 + AN + (wr ? 0 : DC) + 4 * (int'(len) + 1));
        sio_exp.push_back(4'h0);
        sio_exp.push_back(wr ? 4'h2 : 4'h3);
        for (int i = AN - 1; i >= 0; i--) sio_exp.push_back(addr[4*i +: 4]);
        for (int wi = 0; wi <= int'(len); wi++) begin
            if (wr) begin
                w = (wr_fixed.size() != 0) ? wr_fixed.pop_front() : 16'($urandom);
                for (int j = 3; j >= 0; j--) begin
                    sio_exp.push_back(w[4*j +: 4]);
                    wr_src.push_back(w[4*j +: 4]);
                end
            end else begin
                w = mem_word(addr + 16'(wi));
                for (int j = 3; j >= 0; j--) rd_exp.push_back(w[4*j +: 4]);
            end
        end
        bus.i_req_vld  = 1'b1;
        bus.i_req_wr   = wr;
        bus.i_req_addr = addr;
        bus.i_req_len  = len;
        n = 0;
        while (!bus.o_req_rdy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) chk(0, "accept_timeout", n, 0);
        @(posedge clk); #1;
        if (!keep_vld) bus.i_req_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sio_exp.size() != 0 || rd_exp.size() != 0 || cs_len_exp.size() != 0 || !bus.o_req_rdy)
               && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) chk(0, "idle_timeout", n, 0);
        chk(wr_src.size() == 0, "wr_ack_count", wr_src.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rdv0;
        bus.i_req_vld  = 1'b0;
        bus.i_req_wr   = 1'b0;
        bus.i_req_addr = '0;
        bus.i_req_len  = '0;
        bus.i_wr_data  = '0;
        bus.i_sqi_sio  = '0;

        #2 rst_n = 1'b0;
        #1;
        chk(bus.o_sqi_cs_n == 1'b1, "rst_cs_n", bus.o_sqi_cs_n, 1);
        chk(bus.o_sqi_oe == 1'b0, "rst_oe", bus.o_sqi_oe, 0);
        chk(bus.o_sqi_sio == 4'h0, "rst_sio", bus.o_sqi_sio, 0);
        chk(bus.o_rd_vld == 1'b0, "rst_rd_vld", bus.o_rd_vld, 0);
        chk(bus.o_rd_data == 4'h0, "rst_rd_data", bus.o_rd_data, 0);
        chk(bus.o_buf_wr_en == 1'b0, "rst_buf_wr_en", bus.o_buf_wr_en, 0);
        chk(bus.o_wr_ack == 1'b0, "rst_wr_ack", bus.o_wr_ack, 0);
        chk(bus.o_req_rdy == 1'b1, "rst_req_rdy", bus.o_req_rdy, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // directed read and write
        issue(1'b0, 16'h1234, 8'd0, 1'b0);
        wait_idle();
        wr_fixed.push_back(16'hBEEF);
        wr_fixed.push_back(16'h1234);
        issue(1'b1, 16'hFFFF, 8'd1, 1'b0);
        wait_idle();

        // back-to-back with vld held high
        issue(1'b0, 16'h00A5, 8'd0, 1'b1);
        @(posedge clk); #1;
        gap_armed = 1;
        issue(1'b1, 16'h5A00, 8'd1, 1'b0);
        wait_idle();
        chk(gap_armed == 0, "b2b_gap_observed", gap_armed, 0);

        // longest read
        rdv0 = rdv_total;
        issue(1'b0, 16'hFF80, 8'd255, 1'b0);
        wait_idle();
        chk(rdv_total - rdv0 == 1024, "len255_rd_vld_count", rdv_total - rdv0, 1024);

        // request inputs wiggled while busy
        issue(1'b0, 16'h0F0F, 8'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.i_req_vld  = 1'b1;
            bus.i_req_wr   = 1'($urandom);
            bus.i_req_addr = 16'($urandom);
            bus.i_req_len  = 8'($urandom);
            chk(bus.o_req_rdy == 1'b0, "rdy_low_while_busy", bus.o_req_rdy, 0);
            @(posedge clk); #1;
        end
        bus.i_req_vld = 1'b0;
        wait_idle();

        // reset in the third write data cycle
        issue(1'b1, 16'hC0DE, 8'd3, 1'b0);
        n = 0;
        while (n < 2) begin
            @(negedge clk);
            if (bus.o_wr_ack) n++;
        end
        @(posedge clk); #2;
        chk(bus.o_wr_ack == 1'b1, "third_data_cycle_ack", bus.o_wr_ack, 1);
        rst_n = 1'b0;
        #1;
        chk(bus.o_sqi_cs_n == 1'b1, "abort_cs_n", bus.o_sqi_cs_n, 1);
        chk(bus.o_sqi_oe == 1'b0, "abort_oe", bus.o_sqi_oe, 0);
        chk(bus.o_req_rdy == 1'b1, "abort_rdy", bus.o_req_rdy, 1);
        sio_exp.delete();
        rd_exp.delete();
        wr_src.delete();
        cs_len_exp.delete();
        cs_cnt  = 0;
        gap_cnt = 100;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 16'h4321, 8'd1, 1'b0);
        wait_idle();

        // randomized traffic
        for (int t = 0; t < 20; t++) begin
            issue(1'($urandom), 16'($urandom), 8'($urandom_range(0, 3)), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
